// File: rtl/mfm_pkg.sv
// Constants, state encoding and byte-wise CRC-CCITT shared by the MFM sync deserializer.
// Combinational helpers only; no latency, no backpressure.
package mfm_pkg;
    localparam logic [15:0] SYNC_WORD = 16'h4489;
    localparam logic [15:0] IDX_WORD  = 16'h5224;
    localparam logic [7:0]  A1_BYTE   = 8'hA1;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'h1021;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        end
        return c;
    endfunction
endpackage

// File: rtl/mfm_cell_sampler.sv
// Registers window clock and raw-read, flags a raw '1' per bit cell and strobes at each cell edge.
// bit_stb one cycle after the sampled rclk edge; no backpressure.
module mfm_cell_sampler (
    input  logic fclk,
    input  logic rst,
    input  logic vg_rclk,
    input  logic vg_rawr,
    output logic bit_stb,
    output logic bit_val
);
    logic rclk_r_q, rclk_h_q, rawr_r_q, rawr_h_q, flag_q, prime_q;
    logic boundary, fall;

    assign boundary = rclk_r_q ^ rclk_h_q;
    assign fall     = rawr_h_q & ~rawr_r_q;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            rclk_r_q <= 1'b0;
            rclk_h_q <= 1'b0;
            rawr_r_q <= 1'b1;
            rawr_h_q <= 1'b1;
            flag_q   <= 1'b0;
            prime_q  <= 1'b0;
        end else begin
            rclk_r_q <= vg_rclk;
            rclk_h_q <= rclk_r_q;
            rawr_r_q <= vg_rawr;
            rawr_h_q <= rawr_r_q;
            if (boundary) prime_q <= 1'b1;
            // A pulse landing on the edge belongs to the cell that is just opening.
            if (fall)          flag_q <= 1'b1;
            else if (boundary) flag_q <= 1'b0;
        end
    end

    assign bit_stb = boundary & prime_q;
    assign bit_val = flag_q;
endmodule

// File: rtl/mfm_sync_deser.sv
// MFM bit stream -> A1 sync hunt, byte framing and running CRC-16; dstb two cycles after a cell edge.
// No backpressure: every framed byte is strobed once and must be taken.
module mfm_sync_deser
    import mfm_pkg::*;
#(
    parameter int MIN_SYNC = 3
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       vg_rclk,
    input  logic       vg_rawr,
    input  logic       resync,
    output logic [7:0] dout,
    output logic       dstb,
    output logic       dmark,
    output logic       crc_ok,
    output logic       in_frame
);
    localparam logic [1:0]  MIN_SYNC_C  = 2'(MIN_SYNC);
    localparam logic [15:0] CRC_A1_INIT = crc16_byte(CRC_INIT, A1_BYTE);

    logic        bit_stb, bit_val;
    logic [15:0] raw_q, crc_q, crc_a1_d, crc_dat_d;
    logic        upd_q, dstb_q, dmark_q, crc_ok_q, in_frame_q;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  sync_cnt_q, sync_inc_d;
    logic [7:0]  dout_q, data_byte;
    logic        is_sync, wrap;
    state_t      state_q;

    mfm_cell_sampler u_sampler (
        .fclk    (fclk),
        .rst     (rst),
        .vg_rclk (vg_rclk),
        .vg_rawr (vg_rawr),
        .bit_stb (bit_stb),
        .bit_val (bit_val)
    );

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            raw_q <= 16'h0000;
            upd_q <= 1'b0;
        end else begin
            upd_q <= bit_stb;
            if (bit_stb) raw_q <= {raw_q[14:0], bit_val};
        end
    end

    assign data_byte  = {raw_q[14], raw_q[12], raw_q[10], raw_q[8],
                         raw_q[6],  raw_q[4],  raw_q[2],  raw_q[0]};
    assign is_sync    = (raw_q == SYNC_WORD);
    assign wrap       = (bit_cnt_q == 4'd0);
    assign crc_a1_d   = crc16_byte(crc_q, A1_BYTE);
    assign crc_dat_d  = crc16_byte(crc_q, data_byte);
    assign bit_cnt_d  = bit_cnt_q + {3'b000, bit_stb};
    assign sync_inc_d = (sync_cnt_q == 2'd3) ? 2'd3 : sync_cnt_q + 2'd1;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            sync_cnt_q <= 2'd0;
            bit_cnt_q  <= 4'd0;
            crc_q      <= CRC_INIT;
            dout_q     <= 8'h00;
            dstb_q     <= 1'b0;
            dmark_q    <= 1'b0;
            crc_ok_q   <= 1'b0;
            in_frame_q <= 1'b0;
        end else begin
            dstb_q    <= 1'b0;
            bit_cnt_q <= bit_cnt_d;
            if (resync) begin
                state_q    <= HUNT;
                in_frame_q <= 1'b0;
                crc_q      <= CRC_INIT;
                sync_cnt_q <= 2'd0;
                dmark_q    <= 1'b0;
            end else if (upd_q) begin
                unique case (state_q)
                    HUNT, DATA: begin
                        if (is_sync) begin
                            state_q    <= SYNC;
                            in_frame_q <= 1'b0;
                            sync_cnt_q <= 2'd1;
                            bit_cnt_q  <= {3'b000, bit_stb};
                            crc_q      <= CRC_A1_INIT;
                        end else if (state_q == DATA && wrap) begin
                            dout_q   <= data_byte;
                            dstb_q   <= 1'b1;
                            dmark_q  <= 1'b0;
                            crc_q    <= crc_dat_d;
                            crc_ok_q <= (crc_dat_d == 16'h0000);
                        end
                    end
                    SYNC: begin
                        if (is_sync) begin
                            sync_cnt_q <= sync_inc_d;
                            bit_cnt_q  <= {3'b000, bit_stb};
                            crc_q      <= crc_a1_d;
                        end else if (wrap) begin
                            // The word after the last A1 is the mark byte itself.
                            if (sync_cnt_q >= MIN_SYNC_C) begin
                                state_q    <= DATA;
                                in_frame_q <= 1'b1;
                                dout_q     <= data_byte;
                                dstb_q     <= 1'b1;
                                dmark_q    <= 1'b1;
                                crc_q      <= crc_dat_d;
                                crc_ok_q   <= (crc_dat_d == 16'h0000);
                            end else begin
                                state_q    <= HUNT;
                                sync_cnt_q <= 2'd0;
                                crc_q      <= CRC_INIT;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign dout     = dout_q;
    assign dstb     = dstb_q;
    assign dmark    = dmark_q;
    assign crc_ok   = crc_ok_q;
    assign in_frame = in_frame_q;
endmodule

// File: tb/tb_mfm_sync_deser.sv
// Directed bench: models a data separator (28-clock cells, 4-clock raw pulses) and checks framed bytes.
module tb_mfm_sync_deser;
    import mfm_pkg::*;

    logic       fclk = 1'b0;
    logic       rst = 1'b1;
    logic       vg_rclk = 1'b0;
    logic       vg_rawr = 1'b1;
    logic       resync = 1'b0;
    logic [7:0] dout;
    logic       dstb, dmark, crc_ok, in_frame;

    int          checks = 0;
    int          failures = 0;
    logic [9:0]  stq[$];
    logic [9:0]  expq[$];
    bit          saw_frame = 1'b0;
    logic [15:0] good_crc;
    logic [7:0]  pay [5] = '{8'hFE, 8'h00, 8'h00, 8'h01, 8'h02};

    mfm_sync_deser #(.MIN_SYNC(3)) dut (
        .fclk     (fclk),
        .rst      (rst),
        .vg_rclk  (vg_rclk),
        .vg_rawr  (vg_rawr),
        .resync   (resync),
        .dout     (dout),
        .dstb     (dstb),
        .dmark    (dmark),
        .crc_ok   (crc_ok),
        .in_frame (in_frame)
    );

    always #5 fclk = ~fclk;

    always @(negedge fclk) begin
        if (!rst) begin
            if (dstb) stq.push_back({crc_ok, dmark, dout});
            if (in_frame) saw_frame = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_ser(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [15:0] mfm_enc(input logic [7:0] d, input logic prev);
        logic [15:0] w;
        logic        p;
        w = 16'h0000;
        p = prev;
        for (int i = 7; i >= 0; i--) begin
            w = {w[13:0], ~p & ~d[i], d[i]};
            p = d[i];
        end
        return w;
    endfunction

    task automatic send_bit(input logic b);
        repeat (12) @(negedge fclk);
        if (b) vg_rawr = 1'b0;
        repeat (4) @(negedge fclk);
        vg_rawr = 1'b1;
        repeat (11) @(negedge fclk);
        @(negedge fclk);
        vg_rclk = ~vg_rclk;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) send_bit(w[i]);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_bits(w, 16);
    endtask

    task automatic preamble();
        repeat (4) send_bit(1'b0);
    endtask

    task automatic send_sync(input int n);
        repeat (n) send_word(SYNC_WORD);
    endtask

    task automatic send_frame(input int nsync, input bit corrupt);
        logic [7:0]  b;
        logic [15:0] w;
        logic        prev;
        send_sync(nsync);
        prev = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 5)       b = pay[i];
            else if (i == 5) b = good_crc[15:8];
            else             b = good_crc[7:0];
            w = mfm_enc(b, prev);
            if (corrupt && i == 4) w[0] = ~w[0];
            send_word(w);
            prev = b[0];
        end
        repeat (6) @(negedge fclk);
    endtask

    task automatic exp_frame(input logic [7:0] b4, input logic ok);
        expq.push_back({2'b01, 8'hFE});
        expq.push_back({2'b00, 8'h00});
        expq.push_back({2'b00, 8'h00});
        expq.push_back({2'b00, 8'h01});
        expq.push_back({2'b00, b4});
        expq.push_back({2'b00, good_crc[15:8]});
        expq.push_back({ok, 1'b0, good_crc[7:0]});
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, stq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < stq.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), stq[i], expq[i]);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        vg_rawr = 1'b1;
        resync = 1'b0;
        repeat (3) @(negedge fclk);
        rst = 1'b0;
        stq.delete();
        expq.delete();
        saw_frame = 1'b0;
    endtask

    initial begin
        good_crc = 16'hFFFF;
        repeat (3) good_crc = crc_ser(good_crc, 8'hA1);
        for (int i = 0; i < 5; i++) good_crc = crc_ser(good_crc, pay[i]);

        // reset state
        repeat (3) @(negedge fclk);
        check("rst_dout", dout, 8'h00);
        check("rst_dstb", dstb, 1'b0);
        check("rst_dmark", dmark, 1'b0);
        check("rst_crc_ok", crc_ok, 1'b0);
        check("rst_in_frame", in_frame, 1'b0);
        check("rst_crc", dut.crc_q, 16'hFFFF);
        check("rst_state", 32'(dut.state_q), 32'(HUNT));

        // 1: clean ID field
        do_reset();
        preamble();
        send_frame(3, 1'b0);
        exp_frame(8'h02, 1'b1);
        check_stream("s1");
        check("s1_in_frame", in_frame, 1'b1);

        // 2: too few sync marks
        do_reset();
        preamble();
        send_frame(2, 1'b0);
        check_stream("s2");
        check("s2_saw_frame", saw_frame, 1'b0);
        check("s2_state", 32'(dut.state_q), 32'(HUNT));

        // 3: arbitrary bit offset before the marks
        do_reset();
        preamble();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_frame(3, 1'b0);
        exp_frame(8'h02, 1'b1);
        check_stream("s3");

        // 4: one flipped data bit
        do_reset();
        preamble();
        send_frame(3, 1'b1);
        exp_frame(8'h03, 1'b0);
        check_stream("s4");

        // 5: sync mark arriving inside DATA
        do_reset();
        preamble();
        send_sync(3);
        send_word(mfm_enc(8'hFE, 1'b1));
        send_word(mfm_enc(8'h00, 1'b0));
        send_frame(3, 1'b0);
        expq.push_back({2'b01, 8'hFE});
        expq.push_back({2'b00, 8'h00});
        exp_frame(8'h02, 1'b1);
        check_stream("s5");

        // 6a: resync coincident with the byte-completing evaluation
        do_reset();
        preamble();
        send_sync(3);
        send_word(mfm_enc(8'hFE, 1'b1));
        send_bits(16'hAAAA, 15);
        repeat (27) @(negedge fclk);
        @(negedge fclk);
        vg_rclk = ~vg_rclk;
        @(negedge fclk);
        @(negedge fclk);
        check("s6a_in_frame_before", in_frame, 1'b1);
        resync = 1'b1;
        @(negedge fclk);
        resync = 1'b0;
        check("s6a_dstb", dstb, 1'b0);
        check("s6a_in_frame", in_frame, 1'b0);
        repeat (4) @(negedge fclk);
        check("s6a_crc", dut.crc_q, 16'hFFFF);
        expq.push_back({2'b01, 8'hFE});
        check_stream("s6a");

        // 6b: asynchronous reset mid-byte, then a full frame
        do_reset();
        preamble();
        send_sync(3);
        send_word(mfm_enc(8'hFE, 1'b1));
        send_bits(16'hAAAA, 8);
        check("s6b_pre_dout", dout, 8'hFE);
        check("s6b_pre_dmark", dmark, 1'b1);
        @(negedge fclk);
        rst = 1'b1;
        #1;
        check("s6b_dout", dout, 8'h00);
        check("s6b_dmark", dmark, 1'b0);
        check("s6b_in_frame", in_frame, 1'b0);
        check("s6b_dstb", dstb, 1'b0);
        check("s6b_crc_ok", crc_ok, 1'b0);
        repeat (2) @(negedge fclk);
        rst = 1'b0;
        stq.delete();
        expq.delete();
        preamble();
        send_frame(3, 1'b0);
        exp_frame(8'h02, 1'b1);
        check_stream("s6b");

        // 7: raw pulse on the same sample as the cell edge
        do_reset();
        send_bit(1'b0);
        send_bit(1'b0);
        repeat (27) @(negedge fclk);
        @(negedge fclk);
        vg_rclk = ~vg_rclk;
        vg_rawr = 1'b0;
        repeat (4) @(negedge fclk);
        vg_rawr = 1'b1;
        repeat (23) @(negedge fclk);
        @(negedge fclk);
        vg_rclk = ~vg_rclk;
        send_bit(1'b0);
        repeat (4) @(negedge fclk);
        check("s7_raw", dut.raw_q, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
